// File: rtl/i2s_rx.sv
// I2S receiver: deserialises lrclk/sdata slots MSB-first,
// verifies slot length and delivers left/right pairs.
module i2s_rx #(
  parameter int AUDIO_DW  = 24,
  parameter int prescaler = 32
) (
  input  logic                sclk,
  input  logic                rst,
  input  logic                lrclk,
  input  logic                sdata,
  output logic [AUDIO_DW-1:0] left_chan,
  output logic [AUDIO_DW-1:0] right_chan,
  output logic                sample_valid,
  output logic                locked,
  output logic                frame_err
);

  localparam int CW = $clog2(prescaler + 2);
  localparam logic [CW-1:0] CNT_P   = CW'(prescaler);
  localparam logic [CW-1:0] CNT_MAX = CW'(prescaler + 1);
  localparam logic [CW-1:0] CNT_DW  = CW'(AUDIO_DW);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_SYNC,
    S_LOCKED
  } state_t;

  state_t              state;
  logic                lrclk_d;
  logic [CW-1:0]       cnt;
  logic [AUDIO_DW-1:0] sh;
  logic                slot_ch;
  logic                left_ok;
  logic [AUDIO_DW-1:0] left_hold;
  logic                pend;

  logic                lr_edge;
  logic                in_win;
  logic                done;
  logic                err;
  logic [AUDIO_DW-1:0] word;

  assign lr_edge = lrclk != lrclk_d;
  assign in_win  = (cnt != '0) && (cnt <= CNT_DW);
  assign done    = cnt == CNT_DW;
  assign word    = {sh[AUDIO_DW-2:0], sdata};
  assign err     = (state == S_LOCKED) &&
                   (lr_edge ? (cnt != CNT_P)
                            : (cnt == CNT_P));
  assign locked  = state == S_LOCKED;

  // Track lrclk even in reset so release never fakes an edge
  always_ff @(posedge sclk) begin
    lrclk_d <= lrclk;
  end

  // Slot length counter, channel tag and bit shifter
  always_ff @(posedge sclk) begin
    if (rst) begin
      cnt     <= '0;
      sh      <= '0;
      slot_ch <= 1'b0;
    end else begin
      if (lr_edge) begin
        cnt     <= CW'(1);
        slot_ch <= lrclk;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (in_win) begin
        sh <= word;
      end
    end
  end

  // Lock state machine, error pulse and pair assembly
  always_ff @(posedge sclk) begin
    if (rst) begin
      state     <= S_SEARCH;
      frame_err <= 1'b0;
      left_ok   <= 1'b0;
      left_hold <= '0;
      pend      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      pend      <= 1'b0;
      unique case (state)
        S_SEARCH: begin
          if (lr_edge) begin
            state <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (lr_edge && (cnt == CNT_P)) begin
            state <= S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (err) begin
            state     <= S_SYNC;
            frame_err <= 1'b1;
            left_ok   <= 1'b0;
          end else if (done) begin
            if (!slot_ch) begin
              left_ok   <= 1'b1;
              left_hold <= word;
            end else if (left_ok) begin
              pend    <= 1'b1;
              left_ok <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_SEARCH;
        end
      endcase
    end
  end

  // Output words, updated one cycle after the right LSB lands
  always_ff @(posedge sclk) begin
    if (rst) begin
      left_chan    <= '0;
      right_chan   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= pend;
      if (pend) begin
        left_chan  <= left_hold;
        right_chan <= sh;
      end
    end
  end

endmodule
